// File: rtl/ipv4_tx_arb.sv
// ipv4_tx_arb: packet-granular round-robin arbiter in front of the IPv4 TX header inserter.
// One requester is granted per packet. Its stream and protocol byte are muxed onto the shared
// datapath. The grant is held from the start beat until term or cancel, and then priority moves on.
// Optional feature: define IPV4_TX_ARB_TIMEOUT_EN to abort packets whose requester stalls for
// TIMEOUT cycles while the datapath is ready.
// Handshake: a beat transfers on the shared stream when valid_o & ready_i are both high.
// The granted requester sees ready_o[k] = grant_o[k] & ready_i & ~gap. While ready_o[k] is low,
// it must hold valid/start/term/data/len stable. Nothing is buffered here.
// dbg_state exposes the FSM state: 0 IDLE, 1 GRANT, 2 PKT, 3 GAP.
module ipv4_tx_arb #(
  parameter int N       = 2,
  parameter int DATA_W  = 16,
  parameter int GAP     = 1,
  parameter int TIMEOUT = 64,
  localparam int LEN_W  = $clog2(DATA_W/8+1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N-1:0]        req_i,
  input  logic [N-1:0]        valid_i,
  input  logic [N-1:0]        start_i,
  input  logic [N-1:0]        term_i,
  input  logic [N*DATA_W-1:0] data_i,
  input  logic [N*LEN_W-1:0]  len_i,
  input  logic [N*8-1:0]      prot_i,
  input  logic                ready_i,
  input  logic                cancel_i,
  output logic [N-1:0]        ready_o,
  output logic [N-1:0]        grant_o,
  output logic                valid_o,
  output logic                start_o,
  output logic                term_o,
  output logic [DATA_W-1:0]   data_o,
  output logic [LEN_W-1:0]    len_o,
  output logic [7:0]          prot_o,
  output logic                cancel_o,
  output logic [1:0]          dbg_state
);

  localparam int RR_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_PKT   = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  if (N < 2 || N > 8 || DATA_W != 16 || GAP < 0 || GAP > 3 || TIMEOUT < 1 || TIMEOUT > 255)
  begin : g_bad_cfg
    $error("ipv4_tx_arb: unsupported parameter combination");
  end

  state_t            state_q, state_d;
  logic [N-1:0]      grant_q, grant_d;
  logic [RR_W-1:0]   rr_q, rr_d;
  logic [7:0]        prot_q, prot_d;
  logic [1:0]        gap_q, gap_d;

  logic [N-1:0]      pick_oh;
  logic [7:0]        pick_prot;
  logic              pick_found;
  int                pick_idx;

  logic              g_req, g_valid, g_start, g_term;
  logic [RR_W-1:0]   g_idx, next_rr;
  logic              xfer, proto_err, timeout_hit, rel;

  // Round-robin pick: first pending requester at or after the rr pointer, wrapping N-1 -> 0.
  always_comb begin
    pick_oh    = '0;
    pick_prot  = '0;
    pick_found = 1'b0;
    pick_idx   = 0;
    for (int i = 0; i < N; i++) begin
      pick_idx = (int'(rr_q) + i) % N;
      if (!pick_found && req_i[pick_idx]) begin
        pick_found         = 1'b1;
        pick_oh[pick_idx]  = 1'b1;
        pick_prot          = prot_i[pick_idx*8 +: 8];
      end
    end
  end

  // Output mux driven only by the registered grant; ungranted streams never reach the outputs.
  always_comb begin
    g_req   = 1'b0;
    g_valid = 1'b0;
    g_start = 1'b0;
    g_term  = 1'b0;
    g_idx   = '0;
    data_o  = '0;
    len_o   = '0;
    for (int k = 0; k < N; k++) begin
      if (grant_q[k]) begin
        g_req   = req_i[k];
        g_valid = valid_i[k];
        g_start = start_i[k];
        g_term  = term_i[k];
        g_idx   = RR_W'(k);
        data_o  = data_i[k*DATA_W +: DATA_W];
        len_o   = len_i[k*LEN_W +: LEN_W];
      end
    end
  end

  assign next_rr   = (g_idx == RR_W'(N-1)) ? '0 : g_idx + RR_W'(1);
  assign xfer      = g_valid & ready_i;
  assign valid_o   = g_valid;
  assign start_o   = g_start;
  assign term_o    = g_term;
  assign grant_o   = grant_q;
  assign prot_o    = prot_q;
  assign ready_o   = grant_q & {N{ready_i & (state_q != S_GAP)}};
  assign cancel_o  = cancel_i | proto_err | timeout_hit;
  assign dbg_state = state_q;

`ifdef IPV4_TX_ARB_TIMEOUT_EN
  logic [7:0] stall_q;

  // Count PKT cycles in which the datapath is ready but the granted requester offers no beat.
  always_ff @(posedge clk) begin
    if (reset || state_q != S_PKT || xfer) stall_q <= '0;
    else if (ready_i && !g_valid)          stall_q <= stall_q + 8'd1;
  end

  assign timeout_hit = (state_q == S_PKT) && ready_i && !g_valid && (stall_q == 8'(TIMEOUT-1));
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state logic: grant on request, hold through the packet, release on term/cancel/abort.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    prot_d    = prot_q;
    gap_d     = gap_q;
    proto_err = 1'b0;
    rel       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          grant_d = pick_oh;
          prot_d  = pick_prot;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        if (cancel_i) begin
          rel = 1'b1;
        end else if (g_valid && g_start && ready_i) begin
          if (g_term) rel = 1'b1;
          else        state_d = S_PKT;
        end else if (!g_req) begin
          // Requester withdrew before starting: give up the grant without moving priority.
          grant_d = '0;
          prot_d  = '0;
          state_d = S_IDLE;
        end
      end
      S_PKT: begin
        if (cancel_i) begin
          rel = 1'b1;
        end else if (xfer && g_start) begin
          // A new start without a prior term closes the old packet and aborts it downstream.
          proto_err = 1'b1;
          rel       = 1'b1;
        end else if (xfer && g_term) begin
          rel = 1'b1;
        end else if (timeout_hit) begin
          rel = 1'b1;
        end
      end
      S_GAP: begin
        if (gap_q == 2'd0) state_d = S_IDLE;
        else               gap_d   = gap_q - 2'd1;
      end
      default: state_d = S_IDLE;
    endcase
    if (rel) begin
      grant_d = '0;
      prot_d  = '0;
      rr_d    = next_rr;
      if (GAP == 0) begin
        state_d = S_IDLE;
      end else begin
        state_d = S_GAP;
        gap_d   = 2'(GAP > 0 ? GAP - 1 : 0);
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      prot_q  <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      prot_q  <= prot_d;
      gap_q   <= gap_d;
    end
  end

endmodule
